arbiter_burst_mux: RTL
======================

ARBITER_BURST_MUX -- requirements
Module: arbiter_burst_mux

Interface
REQ-001 Parameter NUM_PORTS, default 6, number of requesting ports; SHALL match the upstream arbiter.
REQ-002 Parameter DATA_WIDTH, default 32, data word width.
REQ-003 Parameter LEN_WIDTH, default 8, burst length field width.
REQ-004 One clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 grant  input  [0:NUM_PORTS-1]  registered one-hot grant from the arbiter; bit 0 = port 0.
REQ-007 active  input  1  arbiter active flag, qualifies grant.
REQ-008 in_data  input  NUM_PORTS*DATA_WIDTH  port p word at bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-009 in_len  input  NUM_PORTS*LEN_WIDTH  port p burst length minus one, same slicing.
REQ-010 in_valid  input  [0:NUM_PORTS-1]  per-port word valid.
REQ-011 in_ready  output  [0:NUM_PORTS-1]  per-port word accept.
REQ-012 done  output  [0:NUM_PORTS-1]  one-cycle pulse: port's burst fully accepted; port SHALL drop its request.
REQ-013 out_data  output  DATA_WIDTH  registered forwarded word.
REQ-014 out_valid / out_ready  output / input  1  downstream valid/ready handshake.
REQ-015 out_last  output  1  marks final word of burst, valid with out_valid.
REQ-016 out_port  output  clog2(NUM_PORTS) (min 1)  index of source port of out_data.
REQ-017 err_grant  output  1  one-cycle pulse: multi-hot grant sampled in IDLE.

Function
REQ-018 FSM states: IDLE, XFER, RELEASE.
REQ-019 IDLE: when active=1 and grant is exactly one-hot, SHALL latch grant (sel), decode index, load count from in_len of that port, go XFER next cycle.
REQ-020 IDLE: grant zero or active=0 -> stay IDLE; multi-hot grant with active=1 -> stay IDLE, pulse err_grant.
REQ-021 in_ready[p] = 1 only in XFER, sel[p]=1, and (out_valid=0 or out_ready=1); all other bits 0.
REQ-022 Input transfer on port p when in_valid[p] & in_ready[p]; word SHALL appear on out_data with out_valid=1 the following cycle (1-cycle latency).
REQ-023 out_data/out_port/out_last SHALL hold stable while out_valid=1 and out_ready=0; out_valid clears when out_ready=1 and no new input transfer.
REQ-024 Count decrements per input transfer; transfer at count=0 SHALL set out_last on that word, pulse done[p] same cycle as the transfer, go RELEASE.
REQ-025 Burst length = in_len+1 words (1 .. 2^LEN_WIDTH); in_len sampled only at IDLE->XFER, later changes ignored.
REQ-026 RELEASE: wait until (grant & sel)==0, then IDLE; prevents re-capture of stale grant (arbiter grant lags request by >=1 cycle).
REQ-027 Grant bit of sel dropping during XFER SHALL be ignored; burst completes.
REQ-028 Maximum throughput in XFER: one word per cycle with out_ready held 1.
REQ-029 Minimum gap between bursts: IDLE capture cycle plus RELEASE cycle(s).

Reset
REQ-030 rst=0 SHALL immediately force IDLE, sel=0, count=0, out_valid=0, out_last=0, out_data=0, out_port=0, in_ready=0, done=0, err_grant=0.
REQ-031 Reset mid-burst SHALL discard the burst; no done pulse; after release, first new one-hot grant starts a fresh burst.

Verification
REQ-032 grant=6'b001000, active=1, in_len[2]=3, in_valid[2]=1, out_ready=1 -> 4 words out, out_port=2, out_last on 4th, done[2] single pulse, first out_valid 2 cycles after grant sampled.
REQ-033 Same burst with out_ready toggling 1,0,0,1 -> no word lost/duplicated, out_data stable while stalled, in_ready[2]=0 when out_valid=1 & out_ready=0.
REQ-034 grant held 3 cycles after done[2] -> block stays RELEASE, no second burst; grant to port 5 afterwards -> burst from port 5 only.
REQ-035 grant=6'b100100, active=1 -> err_grant pulse, state IDLE, all in_ready=0.
REQ-036 rst=0 asserted mid-burst after 2 of 4 words -> outputs zero same cycle asynchronously, no done; next burst in_len=0 -> exactly 1 word with out_last=1.
REQ-037 in_len=255 (LEN_WIDTH=8) -> 256 words, out_last only on 256th.

Source files
------------

// File: rtl/arbiter_burst_mux.sv
`default_nettype none
// arbiter_burst_mux: forwards the burst of the single granted port to a registered valid/ready output.
// Revision 1.0
module arbiter_burst_mux #(
  parameter int NUM_PORTS  = 6,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [0:NUM_PORTS-1]            grant,
  input  logic                            active,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS*LEN_WIDTH-1:0]  in_len,
  input  logic [0:NUM_PORTS-1]            in_valid,
  output logic [0:NUM_PORTS-1]            in_ready,
  output logic [0:NUM_PORTS-1]            done,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic [IDX_W-1:0]                out_port,
  output logic                            err_grant
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] XFER    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [0:NUM_PORTS-1]  r_sel;
  logic [IDX_W-1:0]      r_idx;
  logic [LEN_WIDTH-1:0]  r_count;
  logic [IDX_W-1:0]      w_grant_idx;
  logic [LEN_WIDTH-1:0]  w_grant_len;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_grant_any;
  logic                  w_grant_multi;
  logic                  w_capture;
  logic                  w_can_accept;
  logic                  w_xfer;
  logic                  w_last_xfer;

  // Grant decode: index and burst length of the granted port, plus a multi-hot flag.
  always_comb begin
    w_grant_any   = 1'b0;
    w_grant_multi = 1'b0;
    w_grant_idx   = '0;
    w_grant_len   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        if (w_grant_any) begin
          w_grant_multi = 1'b1;
        end else begin
          w_grant_idx = IDX_W'(p);
          w_grant_len = in_len[p*LEN_WIDTH +: LEN_WIDTH];
        end
        w_grant_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_sel[p]) w_sel_data = in_data[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_capture    = (r_state == IDLE) && active && w_grant_any && !w_grant_multi;
  assign w_can_accept = !out_valid || out_ready;
  assign w_xfer       = |(in_valid & in_ready);
  assign w_last_xfer  = w_xfer && (r_count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // RELEASE holds off until the arbiter has withdrawn the stale grant.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_capture) w_next_state = XFER;
      XFER:    if (w_last_xfer) w_next_state = RELEASE;
      RELEASE: if ((grant & r_sel) == '0) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = '0;
    done      = '0;
    err_grant = 1'b0;
    if (r_state == XFER && w_can_accept) in_ready = r_sel;
    done      = in_valid & in_ready & {NUM_PORTS{r_count == '0}};
    err_grant = rst && (r_state == IDLE) && active && w_grant_multi;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel     <= '0;
      r_idx     <= '0;
      r_count   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_port  <= '0;
    end else begin
      if (w_capture) begin
        r_sel   <= grant;
        r_idx   <= w_grant_idx;
        r_count <= w_grant_len;
      end else if (w_xfer) begin
        r_count <= r_count - LEN_WIDTH'(1);
      end
      if (w_xfer) begin
        out_data  <= w_sel_data;
        out_valid <= 1'b1;
        out_last  <= (r_count == '0);
        out_port  <= r_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire
